byte_striping_tx_param: RTL
===========================

Name: byte_striping_tx_param

Overview:
- Parametrised successor to the 4-lane byte striper on the transmit side of the PCIe-like link.
- Distributes a serial stream of valid-qualified words round-robin across LANES output lanes.
- Presents each completed group to the per-lane serialisers as one aligned, single-cycle strobe.
- Adds flush of partial groups with padding and a lane mask, plus a group counter for link monitoring.

Parameters:
- DATA_W, 8, width of one input word and of each lane.
- LANES, 4, number of output lanes; legal range 2..16.
- PAD, 8'hBC (DATA_W bits), filler written to unfilled lanes on flush.
- CNT_W, 16, width of the group counter.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid  input  1  data is a word to stripe this cycle.
- data  input  DATA_W  input word.
- flush  input  1  emit the current partial group, padded.
- data_out  output  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- valid_out  output  1  one-cycle strobe; data_out and lane_mask hold a group.
- lane_mask  output  LANES  bit i = lane i carries real data (not PAD).
- lane_ptr  output  clog2(LANES)  lane that the next accepted word fills.
- group_count  output  CNT_W  number of groups emitted, full plus flushed.

Behaviour:
- Reset, synchronous with priority over all inputs:
  - data_out = 0, valid_out = 0, lane_mask = 0, lane_ptr = 0, group_count = 0.
  - The internal staging buffer and fill mask are cleared.
- Internal state:
  - Staging buffer of LANES words, and fill mask of LANES bits.
  - FSM with two states. EMPTY: mask = 0, ptr = 0. FILLING: 1..LANES-1 words staged.
- Accept, when valid = 1:
  - Stage[ptr] <= data and mask[ptr] <= 1.
  - ptr increments and wraps from LANES-1 to 0.
  - The transition EMPTY -> FILLING occurs on the first accepted word.
- Full group:
  - The word accepted at ptr = LANES-1 completes the group.
  - Next edge: data_out = full stage including that word, lane_mask = all ones, valid_out = 1, group_count += 1.
  - Stage and mask clear, ptr = 0, FSM returns to EMPTY.
  - Latency is one cycle from the last word's edge to the valid_out cycle.
- Flush in FILLING state without valid:
  - Next edge: data_out carries staged lanes plus PAD in every lane with mask = 0.
  - lane_mask = fill mask, valid_out = 1, group_count += 1.
  - Then clear to EMPTY with ptr = 0.
- Flush with valid in the same cycle:
  - The word is included first.
  - If that word completes the group, this is a normal full emission and flush has no extra effect.
  - Otherwise a flushed group is emitted containing the new word.
- Flush in EMPTY state without valid: no-op. No strobe, counter unchanged.
- valid = 0 and flush = 0: state holds, nothing is emitted.
- Output holding rules:
  - valid_out is high for exactly one cycle per group.
  - data_out and lane_mask hold their last value while valid_out = 0. Downstream must sample only on valid_out.
- Back-to-back operation:
  - Continuous valid yields one group every LANES cycles with no bubble.
  - A new group may begin accepting in the same cycle that the previous group's valid_out is high.
- group_count wraps modulo 2^CNT_W silently.
- Reset asserted mid-group discards staged words with no emission. The first post-reset word goes to lane 0.
- No latches: all state lives in clocked registers; next-state logic is fully assigned in every branch.

Test Plan (DATA_W = 8, LANES = 4):
- Reset, then 4 valid words 11, 22, 33, 44 -> one cycle later valid_out = 1, data_out = 44_33_22_11, lane_mask = 1111, group_count = 1, lane_ptr = 0.
- 8 back-to-back words 01..08 -> strobes 4 cycles apart carrying 04030201, then 08070605; group_count = 2; no idle cycle between groups.
- Words AA, BB, then flush alone -> valid_out with data_out = BC_BC_BB_AA, lane_mask = 0011, lane_ptr = 0 afterwards.
- Two sub-cases of flush and valid together:
  - 3 words staged, then valid = 1 with flush = 1, data = 77 -> full group, lane_mask = 1111, exactly one strobe.
  - 1 word staged, then the same stimulus -> lane_mask = 0011.
- Flush while EMPTY, idle gaps between valid words (valid low 5 cycles mid-group) -> no spurious strobe; the group completes correctly after the gap.
- 2 words staged, reset for 1 cycle, then 4 words -> staged data is dropped, all outputs 0 during reset, the next group contains only the post-reset words, group_count = 1.

Source files
------------

// File: rtl/byte_striping_tx_param.sv
// Transmit-side byte striper: distributes valid words round-robin over LANES lanes
// and emits each completed (or flushed, PAD-filled) group as a one-cycle strobe.
module byte_striping_tx_param #(
   parameter int                DATA_W = 8,
   parameter int                LANES  = 4,
   parameter logic [DATA_W-1:0] PAD    = 8'hBC,
   parameter int                CNT_W  = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       valid,
   input  logic [DATA_W-1:0]          data,
   input  logic                       flush,
   output logic [LANES*DATA_W-1:0]    data_out,
   output logic                       valid_out,
   output logic [LANES-1:0]           lane_mask,
   output logic [$clog2(LANES)-1:0]   lane_ptr,
   output logic [CNT_W-1:0]           group_count
);

   localparam int              PTR_W = $clog2(LANES);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(LANES - 1);

   typedef enum logic {EMPTY, FILLING} state_t;

   state_t                         state;
   logic [LANES-1:0][DATA_W-1:0]   stage;
   logic [LANES-1:0][DATA_W-1:0]   stage_nxt;
   logic [LANES-1:0][DATA_W-1:0]   group_nxt;
   logic [LANES-1:0]               mask;
   logic [LANES-1:0]               mask_nxt;
   logic                           full;
   logic                           emit;

   // The incoming word is folded in first, so a flush in the same cycle sees it.
   always_comb begin
      stage_nxt = stage;
      mask_nxt  = mask;
      if (valid) begin
         stage_nxt[lane_ptr] = data;
         mask_nxt[lane_ptr]  = 1'b1;
      end
      for (int i = 0; i < LANES; i++) begin
         group_nxt[i] = mask_nxt[i] ? stage_nxt[i] : PAD;
      end
      full = valid && (lane_ptr == LAST);
      emit = full || (flush && (valid || (state == FILLING)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= EMPTY;
         stage       <= '0;
         mask        <= '0;
         lane_ptr    <= '0;
         data_out    <= '0;
         lane_mask   <= '0;
         valid_out   <= 1'b0;
         group_count <= '0;
      end else begin
         valid_out <= 1'b0;
         if (emit) begin
            data_out    <= group_nxt;
            lane_mask   <= mask_nxt;
            valid_out   <= 1'b1;
            group_count <= group_count + CNT_W'(1);
            stage       <= '0;
            mask        <= '0;
            lane_ptr    <= '0;
            state       <= EMPTY;
         end else if (valid) begin
            stage    <= stage_nxt;
            mask     <= mask_nxt;
            lane_ptr <= lane_ptr + PTR_W'(1);
            state    <= FILLING;
         end
      end
   end

endmodule
